// File: rtl/uart_byte_receiver.sv
// ---------------------------------------------------------------------------
// uart_byte_receiver
//   Receive-side UART front end for the Trax move link. Recovers 8N1 bytes
//   from the asynchronous serial line and hands each good byte to the move
//   transceiver with a one-clock strobe.
//
//   Ports
//     clock        in   1  system clock, all state on posedge
//     reset        in   1  asynchronous, active-low reset
//     rx           in   1  serial line, idle high, asynchronous to clock
//     rx_data      out  8  last correctly framed byte (LSB received first)
//     rx_finish    out  1  one-clock pulse: rx_data just updated
//     frame_error  out  1  one-clock pulse: stop bit sampled low
//     busy         out  1  high from start-edge detection until back in IDLE
// ---------------------------------------------------------------------------
module uart_byte_receiver #(
   parameter int clk_rate  = 9600000,
   parameter int baud_rate = 9600
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_finish,
   output logic       frame_error,
   output logic       busy
);

   localparam int TIME_UNIT = clk_rate / baud_rate;
   localparam int MID       = TIME_UNIT / 2;
   localparam int CW        = (TIME_UNIT > 1) ? $clog2(TIME_UNIT) : 1;

   localparam logic [CW-1:0] C_LAST = CW'(TIME_UNIT - 1);
   localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
   localparam logic [CW-1:0] C_S1   = CW'(MID);
   localparam logic [CW-1:0] C_DEC  = CW'(MID + 1);

   // The three vote samples and the end-of-bit tick must be distinct counts.
   if (TIME_UNIT < 8) begin : g_bad_rate
      $error("uart_byte_receiver: clk_rate/baud_rate must be >= 8");
   end

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_sync1;
   logic            r_rx_s;
   logic            r_rx_prev;
   logic [CW-1:0]   r_bit_cnt;
   logic [2:0]      r_bit_idx;
   logic            r_smp0;
   logic            r_smp1;
   logic [7:0]      r_shift;

   logic            w_vote;
   logic            w_dec;
   logic            w_last;
   logic            w_stop_dec;

   // Third sample is the live rx_s, taken in the decision cycle itself.
   assign w_vote     = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);
   assign w_dec      = (r_bit_cnt == C_DEC);
   assign w_last     = (r_bit_cnt == C_LAST);
   assign w_stop_dec = (r_state == S_STOP) && w_dec;
   assign busy       = (r_state != S_IDLE);

   // ---------------- next-state ----------------
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            // Only a fresh 1->0 edge starts a frame; a held-low line does not.
            if (r_rx_prev && !r_rx_s) w_next = S_START;
         end
         S_START: begin
            if (w_dec && w_vote) w_next = S_IDLE;   // start bit was a glitch
            else if (w_last)     w_next = S_DATA;
         end
         S_DATA: begin
            if (w_last && (r_bit_idx == 3'd7)) w_next = S_STOP;
         end
         S_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (w_dec) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- state register ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // ---------------- synchroniser and datapath ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1     <= 1'b1;
         r_rx_s      <= 1'b1;
         r_rx_prev   <= 1'b1;
         r_bit_cnt   <= '0;
         r_bit_idx   <= 3'd0;
         r_smp0      <= 1'b1;
         r_smp1      <= 1'b1;
         r_shift     <= 8'h00;
         rx_data     <= 8'h00;
         rx_finish   <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         r_sync1   <= rx;
         r_rx_s    <= r_sync1;
         r_rx_prev <= r_rx_s;

         // Counter is held at 0 in IDLE so START always begins at count 0.
         if (r_state == S_IDLE) r_bit_cnt <= '0;
         else if (w_last)       r_bit_cnt <= '0;
         else                   r_bit_cnt <= r_bit_cnt + 1'b1;

         if (r_state == S_START)                r_bit_idx <= 3'd0;
         else if (r_state == S_DATA && w_last)  r_bit_idx <= r_bit_idx + 3'd1;

         if (r_bit_cnt == C_S0) r_smp0 <= r_rx_s;
         if (r_bit_cnt == C_S1) r_smp1 <= r_rx_s;

         if (r_state == S_DATA && w_dec) r_shift[r_bit_idx] <= w_vote;

         rx_finish   <= w_stop_dec &&  w_vote;
         frame_error <= w_stop_dec && !w_vote;
         if (w_stop_dec && w_vote) rx_data <= r_shift;
      end
   end

endmodule

// File: tb/tb_uart_byte_receiver.sv
module tb_uart_byte_receiver;

   // Scaled-down bit time keeps the run short; all timing below is in TU terms.
   localparam int CLK_RATE = 960000;
   localparam int BAUD     = 9600;
   localparam int TU       = CLK_RATE / BAUD;   // 100
   localparam int MID      = TU / 2;            // 50
   localparam int PER      = 10;                // clock period in time units

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] rx_data;
   logic       rx_finish;
   logic       frame_error;
   logic       busy;

   uart_byte_receiver #(.clk_rate(CLK_RATE), .baud_rate(BAUD)) dut (
      .clock       (clock),
      .reset       (reset),
      .rx          (rx),
      .rx_data     (rx_data),
      .rx_finish   (rx_finish),
      .frame_error (frame_error),
      .busy        (busy)
   );

   always #(PER/2) clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   // ---------------- output monitor ----------------
   int         n_fin  = 0;
   int         n_fe   = 0;
   int         n_wide = 0;
   int         n_both = 0;
   bit         prev_fin = 1'b0;
   bit         prev_fe  = 1'b0;
   longint     t_fin    = 0;
   logic [7:0] q_bytes[$];

   always @(negedge clock) begin
      if (reset) begin
         if (rx_finish) begin
            n_fin++;
            q_bytes.push_back(rx_data);
            if (prev_fin) n_wide++;
            else          t_fin = $time;
         end
         if (frame_error) begin
            n_fe++;
            if (prev_fe) n_wide++;
         end
         if (rx_finish && frame_error) n_both++;
      end
      prev_fin = rx_finish;
      prev_fe  = frame_error;
   end

   // ---------------- check helpers ----------------
   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
      n_chk++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   // ---------------- serial transmitter ----------------
   longint t_start = 0;

   task automatic send_bit(input logic b, input int per, input bit spike);
      rx = b;
      if (spike) begin
         repeat (per/2) @(negedge clock);
         rx = ~b;
         @(negedge clock);
         rx = b;
         repeat (per - per/2 - 1) @(negedge clock);
      end else begin
         repeat (per) @(negedge clock);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input int per, input logic stop, input bit spike);
      logic [9:0] bits;
      bits    = {stop, d, 1'b0};
      t_start = $time;
      for (int i = 0; i < 10; i++) send_bit(bits[i], per, spike);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [7:0] data;
      int         per;
      logic       stop;
      bit         spike;
      int         exp_fin;
      int         exp_fe;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int         fin0, fe0, base, busy_hi;
      logic [7:0] msg[6];

      vecs[0] = '{8'h00, TU,           1'b1, 1'b0, 1, 0, 8'h00};
      vecs[1] = '{8'hFF, TU,           1'b1, 1'b0, 1, 0, 8'hFF};
      vecs[2] = '{8'h55, TU*103/100,   1'b1, 1'b1, 1, 0, 8'h55};
      vecs[3] = '{8'hAA, TU*103/100,   1'b1, 1'b1, 1, 0, 8'hAA};
      vecs[4] = '{8'h55, TU*97/100,    1'b1, 1'b1, 1, 0, 8'h55};
      vecs[5] = '{8'hAA, TU*97/100,    1'b1, 1'b1, 1, 0, 8'hAA};
      vecs[6] = '{8'h80, TU,           1'b0, 1'b0, 0, 1, 8'hAA};
      vecs[7] = '{8'h01, TU,           1'b1, 1'b0, 1, 0, 8'h01};
      msg     = '{8'h41, 8'h42, 8'h31, 8'h32, 8'h2B, 8'h0A};

      // ---- reset state ----
      repeat (3) @(negedge clock);
      check("reset rx_data", rx_data, 0);
      check("reset rx_finish", rx_finish, 0);
      check("reset frame_error", frame_error, 0);
      check("reset busy", busy, 0);
      reset = 1'b1;
      idle(TU);

      // ---- single 'W' with latency ----
      fin0 = n_fin; fe0 = n_fe;
      send_frame(8'h57, TU, 1'b1, 1'b0);
      idle(2*TU);
      check("W pulses", n_fin - fin0, 1);
      check("W frame_error", n_fe - fe0, 0);
      check("W rx_data", rx_data, 8'h57);
      check_rng("W latency", (t_fin - PER/2 - t_start) / PER, 9*TU+MID+2, 9*TU+MID+4);

      // ---- bad stop bit, then a held-low break ----
      fin0 = n_fin; fe0 = n_fe;
      send_frame(8'h42, TU, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (TU) @(negedge clock);
      busy_hi = 0;
      for (int i = 0; i < 4*TU; i++) begin
         @(negedge clock);
         if (busy) busy_hi++;
      end
      check("badstop frame_error", n_fe - fe0, 1);
      check("badstop rx_finish", n_fin - fin0, 0);
      check("badstop rx_data kept", rx_data, 8'h57);
      check("break no retrigger", busy_hi, 0);
      idle(TU);
      send_frame(8'h2F, TU, 1'b1, 1'b0);
      idle(2*TU);
      check("after break rx_data", rx_data, 8'h2F);
      check("after break pulses", n_fin - fin0, 1);

      // ---- glitches on an idle line ----
      fin0 = n_fin; fe0 = n_fe;
      rx = 1'b0;
      repeat (TU/5) @(negedge clock);
      rx = 1'b1;
      repeat (MID + 10 - TU/5) @(negedge clock);
      check("long glitch busy cleared", busy, 0);
      idle(TU);
      rx = 1'b0;
      @(negedge clock);
      rx = 1'b1;
      repeat (5) @(negedge clock);
      check("short glitch detected", busy, 1);
      repeat (MID + 5) @(negedge clock);
      check("short glitch busy cleared", busy, 0);
      idle(TU);
      check("glitch rx_finish", n_fin - fin0, 0);
      check("glitch frame_error", n_fe - fe0, 0);

      // ---- table vectors ----
      for (int v = 0; v < 8; v++) begin
         fin0 = n_fin; fe0 = n_fe;
         send_frame(vecs[v].data, vecs[v].per, vecs[v].stop, vecs[v].spike);
         idle(2*TU);
         check($sformatf("vec%0d rx_finish", v), n_fin - fin0, vecs[v].exp_fin);
         check($sformatf("vec%0d frame_error", v), n_fe - fe0, vecs[v].exp_fe);
         check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_data);
      end

      // ---- back-to-back message, no idle gap ----
      base = q_bytes.size();
      fe0  = n_fe;
      for (int i = 0; i < 6; i++) send_frame(msg[i], TU, 1'b1, 1'b0);
      idle(2*TU);
      check("b2b count", q_bytes.size() - base, 6);
      for (int i = 0; i < 6; i++)
         if (base + i < q_bytes.size()) check($sformatf("b2b byte%0d", i), q_bytes[base+i], msg[i]);
         else                           check($sformatf("b2b byte%0d", i), -1, msg[i]);
      check("b2b frame_error", n_fe - fe0, 0);
      check("pulse width", n_wide, 0);
      check("finish and error together", n_both, 0);

      // ---- reset in the middle of a frame ----
      fin0 = n_fin; fe0 = n_fe;
      fork
         send_frame(8'hF0, TU, 1'b1, 1'b0);
         begin
            repeat (5*TU + TU/2) @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
            check("midreset rx_data", rx_data, 0);
            check("midreset busy", busy, 0);
            check("midreset rx_finish", rx_finish, 0);
            check("midreset frame_error", frame_error, 0);
            repeat (TU) @(negedge clock);
            reset = 1'b1;
         end
      join
      idle(2*TU);
      check("midreset no finish", n_fin - fin0, 0);
      check("midreset no error", n_fe - fe0, 0);
      send_frame(8'h5C, TU, 1'b1, 1'b0);
      idle(2*TU);
      check("post reset rx_data", rx_data, 8'h5C);
      check("post reset pulses", n_fin - fin0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
